// File: rtl/soc_system_pulse_out.sv
// soc_system_pulse_out: Avalon-MM output PIO with per-bit static levels plus
// auto-clearing timed pulses driven by one shared reload counter.
// Optional feature macro: SOC_SYSTEM_PULSE_OUT_IRQ_EN adds the pulse-done irq port,
// the irq_pend flag (PULSE read bit 31) and its clear-on-write (PULSE writedata[31]).
module soc_system_pulse_out #(
  parameter int unsigned WIDTH             = 16,
  parameter logic [15:0] RESET_VALUE       = 16'h0000,
  parameter logic [15:0] DEFAULT_PULSE_LEN = 16'd1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
`ifdef SOC_SYSTEM_PULSE_OUT_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_PULSE = 2'd1;
  localparam logic [1:0] ADDR_LEN   = 2'd2;
  localparam logic [1:0] ADDR_SETCLR = 2'd3;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             pend_q, pend_d;

  logic             wr;
  logic             trig;
  logic             done;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] clr_bits;
  logic             unused_wd;

  assign wr       = chipselect & ~write_n;
  assign wr_bits  = writedata[WIDTH-1:0];
  assign clr_bits = writedata[16 +: WIDTH];
  // Bits above WIDTH (and bit 31 without the irq feature) are intentionally ignored.
  assign unused_wd = ^writedata;

  // Register-file updates: DATA, PULSE_LEN and the SETCLR read-modify-write (clear wins).
  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    if (wr && address == ADDR_DATA) begin
      data_d = wr_bits;
    end else if (wr && address == ADDR_SETCLR) begin
      data_d = (data_q | wr_bits) & ~clr_bits;
    end
    if (wr && address == ADDR_LEN) begin
      len_d = writedata[15:0];
    end
  end

  // Pulse engine: a nonzero PULSE write ORs bits in and reloads the counter; the
  // reload takes priority over the 1->0 expiry so a retrigger never drops the mask.
  always_comb begin
    trig   = wr && (address == ADDR_PULSE) && (|wr_bits);
    done   = 1'b0;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (trig) begin
      mask_d = mask_q | wr_bits;
      cnt_d  = (len_q == 16'd0) ? 16'd1 : len_q;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
      if (cnt_q == 16'd1) begin
        mask_d = '0;
        done   = 1'b1;
      end
    end
  end

`ifdef SOC_SYSTEM_PULSE_OUT_IRQ_EN
  // Pulse-done flag: completion sets it, PULSE write with bit 31 clears it; set wins.
  always_comb begin
    pend_d = pend_q;
    if (done) begin
      pend_d = 1'b1;
    end else if (wr && address == ADDR_PULSE && writedata[31]) begin
      pend_d = 1'b0;
    end
  end

  assign irq = pend_q;
`else
  // Without the irq feature the pending flag is tied off; completion is not recorded.
  always_comb begin
    pend_d = 1'b0;
  end
`endif

  // Read mux and output composition; both are registered below (1-cycle latency).
  always_comb begin
    out_d = data_q | mask_q;
    case (address)
      ADDR_DATA:  rdata_d = 32'(data_q);
      ADDR_PULSE: rdata_d = {pend_q, 31'(mask_q)};
      ADDR_LEN:   rdata_d = {16'd0, len_q};
      default:    rdata_d = 32'd0;
    endcase
  end

  // State registers; reset overrides any write presented on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= RESET_VALUE[WIDTH-1:0];
      mask_q  <= '0;
      len_q   <= DEFAULT_PULSE_LEN;
      cnt_q   <= 16'd0;
      rdata_q <= 32'd0;
      out_q   <= RESET_VALUE[WIDTH-1:0];
      pend_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      pend_q  <= pend_d;
    end
  end

  assign readdata = rdata_q;
  assign out_port = out_q;

endmodule

// File: tb/tb_soc_system_pulse_out.sv
// Directed testbench for soc_system_pulse_out (WIDTH=16, RESET_VALUE=16'h00A5).
module tb_soc_system_pulse_out;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] out_port;
`ifdef SOC_SYSTEM_PULSE_OUT_IRQ_EN
  logic        irq;
`endif

  int tests_run;
  int tests_failed;

  soc_system_pulse_out #(
    .WIDTH(16),
    .RESET_VALUE(16'h00A5),
    .DEFAULT_PULSE_LEN(16'd1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
`ifdef SOC_SYSTEM_PULSE_OUT_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle write: sampled on the next rising edge, returns 1 unit after it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = 32'h0000_FFFF;
    tick(3);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd2;
    tests_run++;
    if (readdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_readdata: got %h expected %h", readdata, 32'd0);
    end
    tests_run++;
    if (out_port !== 16'h00A5) begin
      tests_failed++;
      $display("FAIL reset_out_port: got %h expected %h", out_port, 16'h00A5);
    end
    reset = 1'b0;
    tick(1);
    tests_run++;
    if (readdata !== 32'd1000) begin
      tests_failed++;
      $display("FAIL reset_pulse_len: got %h expected %h", readdata, 32'd1000);
    end
    address = 2'd0;
    tick(1);
    tests_run++;
    if (readdata !== 32'h0000_00A5) begin
      tests_failed++;
      $display("FAIL reset_data_read: got %h expected %h", readdata, 32'h0000_00A5);
    end
  endtask

  task automatic test_data_rw;
    bus_write(2'd0, 32'hFFFF_1234);
    tests_run++;
    if (out_port !== 16'h00A5) begin
      tests_failed++;
      $display("FAIL data_out_latency: got %h expected %h", out_port, 16'h00A5);
    end
    tick(1);
    tests_run++;
    if (out_port !== 16'h1234) begin
      tests_failed++;
      $display("FAIL data_out: got %h expected %h", out_port, 16'h1234);
    end
    tests_run++;
    if (readdata !== 32'h0000_1234) begin
      tests_failed++;
      $display("FAIL data_read: got %h expected %h", readdata, 32'h0000_1234);
    end
  endtask

  task automatic test_pulse;
    logic [15:0] exp;
    bus_write(2'd0, 32'd0);
    bus_write(2'd2, 32'd5);
`ifdef SOC_SYSTEM_PULSE_OUT_IRQ_EN
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL pulse_irq_idle: got %b expected %b", irq, 1'b0);
    end
`endif
    bus_write(2'd1, 32'h0000_0003);
    address = 2'd1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      exp = (i < 5) ? 16'h0003 : 16'h0000;
      tests_run++;
      if (out_port !== exp) begin
        tests_failed++;
        $display("FAIL pulse_out[%0d]: got %h expected %h", i, out_port, exp);
      end
      tests_run++;
      if (readdata[15:0] !== exp) begin
        tests_failed++;
        $display("FAIL pulse_read[%0d]: got %h expected %h", i, readdata[15:0], exp);
      end
    end
  endtask

  task automatic test_retrigger;
    logic [15:0] exp;
    bus_write(2'd1, 32'h0000_0001);
    tick(2);
    tests_run++;
    if (out_port !== 16'h0001) begin
      tests_failed++;
      $display("FAIL retrig_first: got %h expected %h", out_port, 16'h0001);
    end
    bus_write(2'd1, 32'h0000_0004);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      exp = (i < 5) ? 16'h0005 : 16'h0000;
      tests_run++;
      if (out_port !== exp) begin
        tests_failed++;
        $display("FAIL retrig_out[%0d]: got %h expected %h", i, out_port, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp;
`ifdef SOC_SYSTEM_PULSE_OUT_IRQ_EN
    bus_write(2'd1, 32'h8000_0000);
`endif
    bus_write(2'd1, 32'h0000_0002);
    tick(4);
    bus_write(2'd1, 32'h0000_0002);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      exp = (i < 5) ? 16'h0002 : 16'h0000;
      tests_run++;
      if (out_port !== exp) begin
        tests_failed++;
        $display("FAIL b2b_out[%0d]: got %h expected %h", i, out_port, exp);
      end
`ifdef SOC_SYSTEM_PULSE_OUT_IRQ_EN
      if (i == 0) begin
        tests_run++;
        if (irq !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_no_irq: got %b expected %b", irq, 1'b0);
        end
      end
`endif
    end
  endtask

  task automatic test_setclr_len0;
    logic [31:0] exp_p;
    bus_write(2'd0, 32'd0);
    bus_write(2'd3, 32'h0003_0006);
    address = 2'd0;
    tick(1);
    tests_run++;
    if (readdata !== 32'h0000_0004) begin
      tests_failed++;
      $display("FAIL setclr_data: got %h expected %h", readdata, 32'h0000_0004);
    end
    address = 2'd3;
    tick(1);
    tests_run++;
    if (readdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL setclr_read: got %h expected %h", readdata, 32'd0);
    end
    bus_write(2'd2, 32'd0);
    bus_write(2'd1, 32'h0000_0001);
    tick(1);
    tests_run++;
    if (out_port !== 16'h0005) begin
      tests_failed++;
      $display("FAIL len0_pulse: got %h expected %h", out_port, 16'h0005);
    end
    tick(1);
    tests_run++;
    if (out_port !== 16'h0004) begin
      tests_failed++;
      $display("FAIL len0_end: got %h expected %h", out_port, 16'h0004);
    end
    address = 2'd2;
    tick(1);
    tests_run++;
    if (readdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL len0_read: got %h expected %h", readdata, 32'd0);
    end
`ifdef SOC_SYSTEM_PULSE_OUT_IRQ_EN
    exp_p = 32'h8000_0000;
`else
    exp_p = 32'h0000_0000;
`endif
    address = 2'd1;
    tick(1);
    tests_run++;
    if (readdata !== exp_p) begin
      tests_failed++;
      $display("FAIL done_pulse_read: got %h expected %h", readdata, exp_p);
    end
  endtask

`ifdef SOC_SYSTEM_PULSE_OUT_IRQ_EN
  task automatic test_irq;
    bus_write(2'd1, 32'h8000_0000);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_clear0: got %b expected %b", irq, 1'b0);
    end
    bus_write(2'd2, 32'd2);
    bus_write(2'd1, 32'h0000_0001);
    tick(2);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_set: got %b expected %b", irq, 1'b1);
    end
    address = 2'd1;
    tick(1);
    tests_run++;
    if (readdata !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL irq_read: got %h expected %h", readdata, 32'h8000_0000);
    end
    bus_write(2'd1, 32'h8000_0000);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_clear: got %b expected %b", irq, 1'b0);
    end
    bus_write(2'd2, 32'd1);
    bus_write(2'd1, 32'h0000_0001);
    bus_write(2'd1, 32'h8000_0000);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_set_wins: got %b expected %b", irq, 1'b1);
    end
    bus_write(2'd1, 32'h8000_0001);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_clear_trig: got %b expected %b", irq, 1'b0);
    end
    tick(1);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_after_trig: got %b expected %b", irq, 1'b1);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    address      = 2'd0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    writedata    = 32'd0;
    test_reset();
    test_data_rw();
    test_pulse();
    test_retrigger();
    test_back_to_back();
    test_setclr_len0();
`ifdef SOC_SYSTEM_PULSE_OUT_IRQ_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
